// File: rtl/ahb_seg7_scan_if.sv
// AHB-lite slave bundle for the seven-segment scanner.
// Master drives the address/data phase; slave answers.
interface ahb_seg7_scan_if;
  logic        HSEL;
  logic        HREADY;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HREADY, HWRITE,
    output HADDR, HTRANS, HSIZE,
    output HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HREADY, HWRITE,
    input  HADDR, HTRANS, HSIZE,
    input  HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_seg7_scan.sv
// AHB-lite seven-segment store with HC595 scan-out.
// Up to 16 digits, raw/decode modes, blanking, PWM.
module ahb_seg7_scan #(
  parameter int NUM_DIGITS      = 8,
  parameter int CLK_DIV         = 24,
  parameter bit SEG_ACTIVE_LOW  = 1'b1,
  parameter bit DIG_ACTIVE_HIGH = 1'b1
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  ahb_seg7_scan_if.slave bus,
  output logic           SH_CLK,
  output logic           LD_CLK,
  output logic           HC_DAT
);

  localparam int POS_W = (NUM_DIGITS <= 8) ? 8 : 16;
  localparam int W     = 8 + POS_W;
  localparam int TW    =
    (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_DAT,
    S_SCLK,
    S_LAT,
    S_LATEND
  } state_e;

  function automatic logic [7:0] glyph(
    input logic [3:0] v
  );
    logic [7:0] g;
    unique case (v)
      4'h0: g = 8'h3F;
      4'h1: g = 8'h06;
      4'h2: g = 8'h5B;
      4'h3: g = 8'h4F;
      4'h4: g = 8'h66;
      4'h5: g = 8'h6D;
      4'h6: g = 8'h7D;
      4'h7: g = 8'h07;
      4'h8: g = 8'h7F;
      4'h9: g = 8'h6F;
      4'hA: g = 8'h77;
      4'hB: g = 8'h7C;
      4'hC: g = 8'h39;
      4'hD: g = 8'h5E;
      4'hE: g = 8'h79;
      4'hF: g = 8'h71;
      default: g = 8'h00;
    endcase
    return g;
  endfunction

  logic        ap_vld_q, ap_vld_d;
  logic        ap_wr_q, ap_wr_d;
  logic [7:0]  ap_addr_q, ap_addr_d;
  logic [2:0]  ap_size_q, ap_size_d;
  logic [31:0] rdata_q, rdata_d;
  logic        en_q, en_d;
  logic        raw_q, raw_d;
  logic [3:0]  bright_q, bright_d;
  logic [7:0]  dig_q [16];
  logic [7:0]  dig_d [16];

  logic [TW-1:0] tick_q, tick_d;
  state_e        st_q, st_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [3:0]    digit_q, digit_d;
  logic [3:0]    slot_q, slot_d;
  logic [15:0]   frame_q, frame_d;
  logic          sh_q, sh_d;
  logic          ld_q, ld_d;
  logic          dat_q, dat_d;

  logic          addr_ph;
  logic          wr_en;
  logic [3:0]    lane;
  logic [1:0]    ra;
  logic [31:0]   rd_word;
  logic          tick;
  logic [7:0]    cur;
  logic [7:0]    seg_pat;
  logic [7:0]    seg_on;
  logic          slot_on;
  logic [POS_W-1:0] pos_on;
  logic [W-1:0]  word;
  logic          unused_ok;

  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;
  assign bus.HRDATA    = rdata_q;
  assign SH_CLK        = sh_q;
  assign LD_CLK        = ld_q;
  assign HC_DAT        = dat_q;

  assign unused_ok = ^{bus.HADDR[31:8],
                       bus.HTRANS[0]};

  assign addr_ph = bus.HSEL & bus.HTRANS[1]
                 & bus.HREADY;
  assign wr_en   = ap_vld_q & ap_wr_q;
  assign ra      = bus.HADDR[3:2];
  assign tick    = (tick_q == TW'(CLK_DIV));

  always_comb begin
    ap_vld_d  = 1'b0;
    ap_wr_d   = ap_wr_q;
    ap_addr_d = ap_addr_q;
    ap_size_d = ap_size_q;
    if (addr_ph) begin
      ap_vld_d  = 1'b1;
      ap_wr_d   = bus.HWRITE;
      ap_addr_d = bus.HADDR[7:0];
      ap_size_d = bus.HSIZE;
    end
  end

  // Only naturally aligned byte/half/word accesses write.
  always_comb begin
    lane = 4'b0000;
    unique case (1'b1)
      ap_size_q == 3'd0:
        lane = 4'b0001 << ap_addr_q[1:0];
      ap_size_q == 3'd1 && !ap_addr_q[0]:
        lane = ap_addr_q[1] ? 4'b1100 : 4'b0011;
      ap_size_q == 3'd2 && ap_addr_q[1:0] == 2'd0:
        lane = 4'b1111;
      default:
        lane = 4'b0000;
    endcase
  end

  always_comb begin
    en_d     = en_q;
    raw_d    = raw_q;
    bright_d = bright_q;
    for (int i = 0; i < 16; i++)
      dig_d[i] = dig_q[i];
    if (wr_en && ap_addr_q[7:2] == 6'h00) begin
      if (lane[0]) begin
        en_d  = bus.HWDATA[0];
        raw_d = bus.HWDATA[1];
      end
      if (lane[1])
        bright_d = bus.HWDATA[11:8];
    end
    if (wr_en && ap_addr_q[7:4] == 4'h1) begin
      for (int i = 0; i < 4; i++) begin
        if (lane[i] &&
            int'({ap_addr_q[3:2], 2'(i)})
              < NUM_DIGITS)
          dig_d[{ap_addr_q[3:2], 2'(i)}] =
            bus.HWDATA[8*i +: 8];
      end
    end
  end

  // Reads see this cycle's write so back-to-back is coherent.
  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      bus.HADDR[7:2] == 6'h00:
        rd_word = {20'h0, bright_d, 6'h0,
                   raw_d, en_d};
      bus.HADDR[7:2] == 6'h01:
        rd_word = {frame_q, 8'h0,
                   slot_q, digit_q};
      bus.HADDR[7:4] == 4'h1:
        rd_word = {dig_d[{ra, 2'd3}],
                   dig_d[{ra, 2'd2}],
                   dig_d[{ra, 2'd1}],
                   dig_d[{ra, 2'd0}]};
      default:
        rd_word = '0;
    endcase
    rdata_d = (addr_ph && !bus.HWRITE)
            ? rd_word : 32'h0;
  end

  always_comb begin
    cur     = dig_q[digit_q];
    seg_pat = cur;
    if (!raw_q)
      seg_pat = cur[5] ? 8'h00
              : (glyph(cur[3:0]) | {cur[4], 7'b0});
    slot_on = en_q && (slot_q <= bright_q);
    seg_on  = slot_on ? seg_pat : 8'h00;
    pos_on  = slot_on
            ? (POS_W'(1) << digit_q) : '0;
    word = {SEG_ACTIVE_LOW ? ~seg_on : seg_on,
            DIG_ACTIVE_HIGH ? pos_on : ~pos_on};
  end

  always_comb begin
    tick_d  = tick ? '0 : tick_q + TW'(1);
    st_d    = st_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    slot_d  = slot_q;
    frame_d = frame_q;
    sh_d    = sh_q;
    ld_d    = ld_q;
    dat_d   = dat_q;
    if (tick) begin
      unique case (st_q)
        S_LOAD: begin
          sreg_d = word;
          cnt_d  = '0;
          sh_d   = 1'b0;
          ld_d   = 1'b0;
          st_d   = S_DAT;
        end
        S_DAT: begin
          dat_d = sreg_q[W-1];
          sh_d  = 1'b0;
          st_d  = S_SCLK;
        end
        S_SCLK: begin
          sh_d   = 1'b1;
          sreg_d = sreg_q << 1;
          cnt_d  = cnt_q + 5'd1;
          st_d   = (cnt_q + 5'd1 < 5'(W))
                 ? S_DAT : S_LAT;
        end
        S_LAT: begin
          sh_d = 1'b0;
          ld_d = 1'b1;
          st_d = S_LATEND;
        end
        S_LATEND: begin
          ld_d   = 1'b0;
          st_d   = S_LOAD;
          slot_d = slot_q + 4'd1;
          if (slot_q == 4'hF) begin
            if (digit_q == 4'(NUM_DIGITS - 1)) begin
              digit_d = 4'd0;
              frame_d = frame_q + 16'd1;
            end else begin
              digit_d = digit_q + 4'd1;
            end
          end
        end
        default: st_d = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_vld_q  <= 1'b0;
      ap_wr_q   <= 1'b0;
      ap_addr_q <= '0;
      ap_size_q <= '0;
      rdata_q   <= '0;
      en_q      <= 1'b1;
      raw_q     <= 1'b0;
      bright_q  <= 4'hF;
      for (int i = 0; i < 16; i++)
        dig_q[i] <= 8'h00;
      tick_q    <= '0;
      st_q      <= S_LOAD;
      sreg_q    <= '0;
      cnt_q     <= '0;
      digit_q   <= '0;
      slot_q    <= '0;
      frame_q   <= '0;
      sh_q      <= 1'b0;
      ld_q      <= 1'b0;
      dat_q     <= 1'b0;
    end else begin
      ap_vld_q  <= ap_vld_d;
      ap_wr_q   <= ap_wr_d;
      ap_addr_q <= ap_addr_d;
      ap_size_q <= ap_size_d;
      rdata_q   <= rdata_d;
      en_q      <= en_d;
      raw_q     <= raw_d;
      bright_q  <= bright_d;
      for (int i = 0; i < 16; i++)
        dig_q[i] <= dig_d[i];
      tick_q    <= tick_d;
      st_q      <= st_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      slot_q    <= slot_d;
      frame_q   <= frame_d;
      sh_q      <= sh_d;
      ld_q      <= ld_d;
      dat_q     <= dat_d;
    end
  end

endmodule

// File: tb/tb_ahb_seg7_scan.sv
// Scoreboard bench for ahb_seg7_scan: 8- and 12-digit
// instances checked against a frame-level reference model.
module tb_ahb_seg7_scan;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        hsel8, hsel12, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;

  ahb_seg7_scan_if if8 ();
  ahb_seg7_scan_if if12 ();

  assign if8.HSEL    = hsel8;
  assign if8.HREADY  = 1'b1;
  assign if8.HWRITE  = hwrite;
  assign if8.HADDR   = haddr;
  assign if8.HTRANS  = htrans;
  assign if8.HSIZE   = hsize;
  assign if8.HWDATA  = hwdata;
  assign if12.HSEL   = hsel12;
  assign if12.HREADY = 1'b1;
  assign if12.HWRITE = hwrite;
  assign if12.HADDR  = haddr;
  assign if12.HTRANS = htrans;
  assign if12.HSIZE  = hsize;
  assign if12.HWDATA = hwdata;

  logic sh [2];
  logic ld [2];
  logic dat [2];

  ahb_seg7_scan #(.NUM_DIGITS(8), .CLK_DIV(0)) dut8 (
    .HCLK(clk), .HRESETn(rst_n), .bus(if8.slave),
    .SH_CLK(sh[0]), .LD_CLK(ld[0]), .HC_DAT(dat[0])
  );

  ahb_seg7_scan #(.NUM_DIGITS(12), .CLK_DIV(0)) dut12 (
    .HCLK(clk), .HRESETn(rst_n), .bus(if12.slave),
    .SH_CLK(sh[1]), .LD_CLK(ld[1]), .HC_DAT(dat[1])
  );

  localparam logic [7:0] GLYPH [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  localparam int NDIG [2]  = '{8, 12};
  localparam int WBITS [2] = '{16, 24};
  localparam logic [7:0] ADDRS [18] = '{
    8'h00, 8'h01, 8'h02, 8'h03, 8'h08, 8'h0C,
    8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h16,
    8'h18, 8'h1B, 8'h1C, 8'h1E, 8'h20, 8'h90};

  int total = 0;
  int bad = 0;

  bit         m_en [2];
  bit         m_raw [2];
  int         m_bright [2];
  logic [7:0] m_dig [2][16];
  int         wr_cnt [2];

  logic [31:0] rq [2][$];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_en[u] = 1'b1;
      m_raw[u] = 1'b0;
      m_bright[u] = 15;
      for (int i = 0; i < 16; i++) m_dig[u][i] = 8'h00;
    end
  endtask

  task automatic model_wr(input int u,
                          input logic [31:0] a,
                          input logic [2:0] sz,
                          input logic [31:0] d);
    int base, lo, nb, idx;
    logic [7:0] b;
    base = int'(a[7:2]) * 4;
    lo = int'(a[1:0]);
    nb = 0;
    if (sz == 3'd0) nb = 1;
    else if (sz == 3'd1 && (lo == 0 || lo == 2)) nb = 2;
    else if (sz == 3'd2 && lo == 0) nb = 4;
    for (int k = lo; k < lo + nb; k++) begin
      b = 8'(d >> (8 * k));
      if (base == 0) begin
        if (k == 0) begin
          m_en[u] = b[0];
          m_raw[u] = b[1];
        end
        if (k == 1) m_bright[u] = int'(b[3:0]);
      end else if (base >= 16 && base <= 28) begin
        idx = base - 16 + k;
        if (idx < NDIG[u]) m_dig[u][idx] = b;
      end
    end
  endtask

  function automatic logic [31:0] model_rd(
    input int u, input logic [31:0] a);
    int base, idx;
    logic [31:0] r;
    base = int'(a[7:2]) * 4;
    r = 32'h0;
    if (base == 0) begin
      r = 32'(m_bright[u]) << 8;
      r = r | (m_raw[u] ? 32'h2 : 32'h0)
            | (m_en[u] ? 32'h1 : 32'h0);
    end else if (base >= 16 && base <= 28) begin
      for (int k = 0; k < 4; k++) begin
        idx = base - 16 + k;
        if (idx < NDIG[u])
          r = r | (32'(m_dig[u][idx]) << (8 * k));
      end
    end
    return r;
  endfunction

  // Word n of the scan: digit n/16, slot n%16.
  function automatic logic [31:0] exp_word(
    input int u, input int n);
    int d, s;
    logic [7:0] b, seg;
    logic [31:0] pos, segw;
    d = (n / 16) % NDIG[u];
    s = n % 16;
    b = m_dig[u][d];
    seg = 8'h00;
    pos = 32'h0;
    if (m_en[u] && s <= m_bright[u]) begin
      if (m_raw[u]) seg = b;
      else if (b[5]) seg = 8'h00;
      else seg = GLYPH[b[3:0]] | (b[4] ? 8'h80 : 8'h00);
      pos = 32'd1 << d;
    end
    segw = {24'h0, ~seg};
    return (segw << (WBITS[u] - 8)) | pos;
  endfunction

  task automatic idle_bus();
    hsel8 = 1'b0;
    hsel12 = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic bus_wr(input int u,
                        input logic [31:0] a,
                        input logic [2:0] sz,
                        input logic [31:0] d);
    @(negedge clk); #1;
    hsel8 = (u == 0);
    hsel12 = (u == 1);
    htrans = 2'b10;
    hwrite = 1'b1;
    haddr = a;
    hsize = sz;
    @(negedge clk); #1;
    idle_bus();
    hwdata = d;
    model_wr(u, a, sz, d);
    wr_cnt[u]++;
    @(negedge clk); #1;
  endtask

  task automatic bus_rd(input int u,
                        input logic [31:0] a,
                        input logic [31:0] exp);
    @(negedge clk); #1;
    hsel8 = (u == 0);
    hsel12 = (u == 1);
    htrans = 2'b10;
    hwrite = 1'b0;
    haddr = a;
    hsize = 3'd2;
    rq[u].push_back(exp);
    @(negedge clk); #1;
    idle_bus();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_quiet(input string nm);
    check({nm, "_sh8"}, 32'(sh[0]), 32'h0);
    check({nm, "_ld8"}, 32'(ld[0]), 32'h0);
    check({nm, "_dat8"}, 32'(dat[0]), 32'h0);
    check({nm, "_rd8"}, if8.HRDATA, 32'h0);
    check({nm, "_ld12"}, 32'(ld[1]), 32'h0);
    check({nm, "_rd12"}, if12.HRDATA, 32'h0);
  endtask

  // Read data-phase monitor.
  logic rdph8, rdph12;
  always @(posedge clk) begin
    rdph8 <= hsel8 && htrans[1] && !hwrite;
    rdph12 <= hsel12 && htrans[1] && !hwrite;
  end

  always @(negedge clk) begin
    if (rst_n && rdph8) begin
      if (rq[0].size() == 0) check("rd8_q", 32'h1, 32'h0);
      else check("rd8", if8.HRDATA, rq[0].pop_front());
    end
    if (rst_n && rdph12) begin
      if (rq[1].size() == 0) check("rd12_q", 32'h1, 32'h0);
      else check("rd12", if12.HRDATA, rq[1].pop_front());
    end
  end

  // Serial monitor: rebuild each latched word.
  int         cyc [2];
  int         nwords [2];
  int         nbits [2];
  logic [31:0] acc [2];
  logic       psh [2];
  logic       pld [2];
  int         skip [2];
  int         seen [2];
  bit         first [2];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++)
      cyc[u] = rst_n ? cyc[u] + 1 : 0;
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        nwords[u] = 0;
        nbits[u] = 0;
        acc[u] = 32'h0;
        psh[u] = 1'b0;
        pld[u] = 1'b0;
        skip[u] = 0;
        seen[u] = wr_cnt[u];
        first[u] = 1'b1;
      end else begin
        // Words in flight around a write may use either copy.
        if (seen[u] != wr_cnt[u]) begin
          seen[u] = wr_cnt[u];
          skip[u] = 2;
        end
        if (sh[u] && !psh[u]) begin
          acc[u] = (acc[u] << 1) | 32'(dat[u]);
          nbits[u]++;
        end
        if (ld[u] && !pld[u]) begin
          if (first[u]) begin
            check("ld_first", 32'(cyc[u]),
                  32'(2 * WBITS[u] + 2));
            first[u] = 1'b0;
          end
          check("nbits", 32'(nbits[u]), 32'(WBITS[u]));
          if (skip[u] > 0) skip[u]--;
          else check(u == 0 ? "word8" : "word12",
                     acc[u], exp_word(u, nwords[u]));
          nwords[u]++;
          nbits[u] = 0;
          acc[u] = 32'h0;
        end
        psh[u] = sh[u];
        pld[u] = ld[u];
      end
    end
  end

  initial begin
    int u, n, target, bound;
    logic [31:0] r, a, d, st;
    logic [7:0] a8;
    logic [2:0] sz;
    idle_bus();
    haddr = 32'h0;
    hwdata = 32'h0;
    hsize = 3'd0;
    wr_cnt[0] = 0;
    wr_cnt[1] = 0;
    model_reset();
    rst_n = 1'b0;
    wait_cyc(3);
    check_quiet("rst");
    check("hreadyout", 32'(if8.HREADYOUT), 32'h1);
    check("hresp", 32'(if8.HRESP), 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    bus_rd(0, 32'h0, 32'h0000_0F01);
    bus_rd(0, 32'h10, 32'h0);
    wait_cyc(80);

    bus_wr(0, 32'h10, 3'd0, 32'h0000_0001);
    bus_wr(0, 32'h11, 3'd0, 32'h0000_1800);
    bus_rd(0, 32'h10, 32'h0000_1801);
    bus_rd(0, 32'h10, model_rd(0, 32'h10));
    wait_cyc(1200);

    bus_wr(0, 32'h00, 3'd2, 32'h0000_0301);
    wait_cyc(700);
    bus_wr(0, 32'h00, 3'd2, 32'h0000_0300);
    wait_cyc(200);

    bus_wr(0, 32'h00, 3'd2, 32'h0000_0F03);
    bus_wr(0, 32'h10, 3'd2, 32'h8080_8080);
    bus_wr(0, 32'h14, 3'd2, 32'h8080_8080);
    wait_cyc(200);
    bus_wr(0, 32'h00, 3'd2, 32'h0000_0F01);
    bus_wr(0, 32'h10, 3'd2, 32'h2525_2525);
    bus_wr(0, 32'h14, 3'd2, 32'h2525_2525);
    wait_cyc(200);

    for (int i = 0; i < 24; i++) begin
      u = int'($urandom_range(1, 0));
      r = $urandom;
      a8 = ADDRS[$urandom_range(17, 0)];
      a = {r[31:8], a8};
      sz = 3'($urandom_range(3, 0));
      d = $urandom;
      bus_wr(u, a, sz, d);
      a8 = ADDRS[$urandom_range(17, 0)];
      a = {r[31:8], a8};
      bus_rd(u, a, model_rd(u, a));
      wait_cyc(int'($urandom_range(100, 0)));
    end

    bus_wr(1, 32'h00, 3'd2, 32'h0000_0F01);
    bus_wr(1, 32'h1B, 3'd0, 32'h0500_0000);
    bus_wr(1, 32'h1C, 3'd2, 32'hFFFF_FFFF);
    bus_rd(1, 32'h1C, 32'h0);
    bus_rd(1, 32'h18, model_rd(1, 32'h18));

    target = ((nwords[1] / 192) + 1) * 192 + 5;
    bound = 0;
    while (nwords[1] < target && bound < 14000) begin
      @(negedge clk);
      bound++;
    end
    if (nwords[1] < target) begin
      check("frame_wait", 32'(nwords[1]), 32'(target));
    end else begin
      wait_cyc(3);
      st = {16'(target / 192), 8'h0,
            4'(target % 16), 4'((target / 16) % 12)};
      bus_rd(1, 32'h04, st);
    end

    bus_wr(0, 32'h11, 3'd1, 32'hABCD_EF12);
    bus_wr(0, 32'h12, 3'd2, 32'h1234_5678);
    bus_rd(0, 32'h10, 32'h2525_2525);
    wait_cyc(100);

    bound = 0;
    while (!sh[0] && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    check("mid_sh_seen", 32'(sh[0]), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check_quiet("midrst");
    model_reset();
    wait_cyc(3);
    @(negedge clk); #1;
    rst_n = 1'b1;
    bus_rd(0, 32'h0, 32'h0000_0F01);
    bus_rd(1, 32'h10, 32'h0);
    wait_cyc(120);
    check("post_words", 32'(nwords[0] >= 2), 32'h1);

    wait_cyc(4);
    check("rq8_empty", 32'(rq[0].size()), 32'h0);
    check("rq12_empty", 32'(rq[1].size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
